bus_arbiter: RTL

Sequences ownership of the shared system bus between the CPU and up to NUM_REQ bus masters, such as DMA channels and DRAM refresh. It runs the CPU hold/hold-acknowledge handshake and grants the bus to one requester at a time, using fixed or round-robin priority. It drives address_enable high while a requester owns the bus, which blocks peripheral I/O chip selects. A watchdog forces a release if any grant runs too long.

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_arbiter_priority_select.sv | 35 +++
 rtl/bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and counter widths for the system bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_REQ,
    GRANT,
    RELEASE,
    DROP_HOLD
  } arbiter_state_t;

  localparam int WDOG_W  = 16;  // per-grant watchdog counter
  localparam int GUARD_W = 4;   // inter-grant guard counter

endpackage

// File: rtl/bus_arbiter_priority_select.sv
// Combinational winner search: fixed lowest-index-first, or round-robin
// starting at rr_pointer_i and wrapping from NUM_REQ-1 back to 0.
module bus_arbiter_priority_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request_i,
  input  logic [IDX_W-1:0]   rr_pointer_i,
  input  logic               fixed_priority_i,
  output logic [NUM_REQ-1:0] winner_onehot_o,
  output logic [IDX_W-1:0]   winner_idx_o,
  output logic               any_valid_o
);

  int cand;

  // NOTE: every signal written here gets a default before the loop, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    winner_onehot_o = '0;
    winner_idx_o    = '0;
    any_valid_o     = 1'b0;
    cand            = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = fixed_priority_i ? i : int'(rr_pointer_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_valid_o && request_i[cand]) begin
        any_valid_o           = 1'b1;
        winner_idx_o          = IDX_W'(cand);
        winner_onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Bus ownership sequencer: CPU hold/hold-acknowledge handshake, one-hot
// grant to a single requester, inter-grant guard time and grant watchdog.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int                NUM_REQ          = 4,
  parameter int                GUARD_CYCLES     = 2,
  parameter logic [WDOG_W-1:0] MAX_GRANT_CYCLES = 16'd256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic               fixed_priority,
  input  logic               hold_acknowledge,
  output logic               hold_request,
  output logic [NUM_REQ-1:0] grant,
  output logic               address_enable,
  output logic               grant_timeout,
  output logic               protocol_error
);

  localparam int                 IDX_W      = $clog2(NUM_REQ);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = MAX_GRANT_CYCLES - 1'b1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  arbiter_state_t     state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic [GUARD_W-1:0] guard_q, guard_d;
  logic               ack_q;

  logic [NUM_REQ-1:0] eff_req, sel_onehot, grant_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_valid, enter_grant, timeout_d, perr_d;

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  assign eff_req = request & ~mask_q;

  bus_arbiter_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .request_i        (eff_req),
    .rr_pointer_i     (rr_ptr_q),
    .fixed_priority_i (fixed_priority),
    .winner_onehot_o  (sel_onehot),
    .winner_idx_o     (sel_idx),
    .any_valid_o      (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    rr_ptr_d    = rr_ptr_q;
    mask_d      = mask_q & request;  // a mask bit lives only while its request stays high
    wdog_d      = '0;
    guard_d     = '0;
    enter_grant = 1'b0;
    timeout_d   = 1'b0;
    perr_d      = 1'b0;
    unique case (state_q)
      IDLE: if (sel_valid) state_d = HOLD_REQ;
      HOLD_REQ: begin
        if (ack_q) begin
          if (sel_valid) enter_grant = 1'b1;
          else           state_d     = DROP_HOLD;
        end
      end
      GRANT: begin
        wdog_d = wdog_q + 1'b1;
        if (!ack_q) begin
          perr_d  = 1'b1;
          state_d = DROP_HOLD;
        end else if (!request[winner_q]) begin
          state_d = RELEASE;
        end else if (wdog_q == WDOG_LAST) begin
          timeout_d        = 1'b1;
          mask_d[winner_q] = 1'b1;
          state_d          = RELEASE;
        end
      end
      RELEASE: begin
        guard_d = guard_q + 1'b1;
        if (!ack_q) begin
          perr_d  = 1'b1;
          state_d = DROP_HOLD;
        end else if (guard_q == GUARD_LAST) begin
          if (sel_valid) enter_grant = 1'b1;
          else           state_d     = DROP_HOLD;
        end
      end
      DROP_HOLD: if (!ack_q) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (enter_grant) begin
      state_d  = GRANT;
      winner_d = sel_idx;
      rr_ptr_d = ptr_after(sel_idx);
    end
  end

  always_comb begin
    grant_d = '0;
    if (state_d == GRANT) grant_d[winner_d] = 1'b1;
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      winner_q       <= '0;
      rr_ptr_q       <= '0;
      mask_q         <= '0;
      wdog_q         <= '0;
      guard_q        <= '0;
      ack_q          <= 1'b0;
      hold_request   <= 1'b0;
      grant          <= '0;
      address_enable <= 1'b0;
      grant_timeout  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      rr_ptr_q       <= rr_ptr_d;
      mask_q         <= mask_d;
      wdog_q         <= wdog_d;
      guard_q        <= guard_d;
      ack_q          <= hold_acknowledge;  // CPU handshake is registered once before use
      hold_request   <= (state_d == HOLD_REQ) || (state_d == GRANT) || (state_d == RELEASE);
      grant          <= grant_d;
      address_enable <= (state_d == GRANT) || (state_d == RELEASE) || (state_d == DROP_HOLD);
      grant_timeout  <= timeout_d;
      protocol_error <= perr_d;
    end
  end

endmodule
